// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and helpers for the UART receiver.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int BAUD             = 115200;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Result is 1 when the word plus its parity bit carry an odd number of ones.
  function automatic logic even_parity_error(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; both stages reset to
// the idle (high) level so the receiver never sees a false start after reset.
module uart_rx_sync (
  input  logic clk_50M,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_valid / frame_err strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_50M (clk_50M),
    .reset   (reset),
    .d       (rx),
    .q       (rx_s)
  );

  uart_rx_state_t       state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [7:0]           rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q,      busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q,    par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      // Re-check the line at the middle of the start bit to reject glitches.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end
`endif

      // Returning to IDLE at mid-stop leaves half a bit to catch the next start.
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = even_parity_error(shift_q, par_bit_q);
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of clean frames plus hand-written
// sequences for back-to-back, glitch, break, mid-frame reset and parity.
module tb_uart_rx;

  localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 4125 + CPB;
`else
  localparam int LAT = 4125;
`endif

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx dut (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #10 clk_50M = ~clk_50M;

  int cyc = 0;
  always @(posedge clk_50M) cyc++;

  int         tests     = 0;
  int         failed    = 0;
  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         busy_fall = 0;
  int         perr_cnt  = 0;
  int         valid_cyc = 0;
  int         fall_cyc  = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] last_byte = 8'h00;
  logic [7:0] rx_q[$];

  always @(negedge clk_50M) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      last_byte = rx_data;
      rx_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt++;
    if (rx_valid && frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err && rx_valid) perr_cnt++;
    if (parity_err && !rx_valid) both_cnt++;
`endif
    if (busy_prev && !busy) busy_fall++;
    busy_prev = busy;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    rx       = 1'b0;
    fall_cyc = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^data);
`endif
    send_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_bad_par(input logic [7:0] data);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(~(^data));
    send_bit(1'b1);
  endtask
`endif

  typedef struct {
    logic [7:0] data;
    int         gap;
    int         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] b2b[4];
  int v0, f0, b0, p0, lat;

  initial begin
    vecs[0] = '{data: 8'h55, gap: 20,  exp_valid: 1, exp_data: 8'h55};
    vecs[1] = '{data: 8'h01, gap: 0,   exp_valid: 1, exp_data: 8'h01};
    vecs[2] = '{data: 8'h80, gap: 137, exp_valid: 1, exp_data: 8'h80};
    vecs[3] = '{data: 8'hC3, gap: 5,   exp_valid: 1, exp_data: 8'hC3};
    b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF; b2b[3] = 8'h00;

    // Reset state
    wait_cycles(5);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    wait_cycles(20);

    // Clean frames from a behavioural transmitter, with varied idle gaps
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, 1'b1);
      wait_cycles(vecs[i].gap + 1);
      lat = valid_cyc - fall_cyc;
      $display("[TB] frame 0x%02h -> rx_data 0x%02h, latency %0d", vecs[i].data, last_byte, lat);
      check($sformatf("vec%0d_valid_count", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_rx_data", i), int'(last_byte), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, 0);
      check($sformatf("vec%0d_latency", i), int'(lat >= LAT - 1 && lat <= LAT + 1), 1);
    end

    // Back-to-back frames, one stop bit each
    rx_q.delete();
    b0 = busy_fall; v0 = valid_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1);
    wait_cycles(300);
    $display("[TB] back-to-back: %0d bytes received", rx_q.size());
    check("b2b_valid_count", valid_cnt - v0, 4);
    check("b2b_frame_err", ferr_cnt - f0, 0);
    check("b2b_busy_falls", busy_fall - b0, 4);
    check("b2b_busy_idle", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_byte%0d", i), (rx_q.size() > i) ? int'(rx_q[i]) : -1, int'(b2b[i]));
    end

    // Short low glitch must be rejected
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(10);
    check("glitch_busy_high", int'(busy), 1);
    wait_cycles(90);
    rx = 1'b1;
    wait_cycles(220);
    $display("[TB] glitch: busy %0b", busy);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_no_valid", valid_cnt - v0, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Bad stop bit then a held-low line: exactly one frame_err
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    wait_cycles(5000);
    rx = 1'b1;
    wait_cycles(500);
    $display("[TB] break 0x81: frame_err count %0d, rx_data 0x%02h", ferr_cnt - f0, rx_data);
    check("break_ferr_once", ferr_cnt - f0, 1);
    check("break_no_valid", valid_cnt - v0, 0);
    check("break_rx_data_kept", int'(rx_data), 8'h00);
    check("break_busy_low", int'(busy), 0);
    v0 = valid_cnt;
    send_frame(8'h42, 1'b1);
    wait_cycles(20);
    $display("[TB] frame 0x42 -> rx_data 0x%02h", last_byte);
    check("after_break_valid", valid_cnt - v0, 1);
    check("after_break_data", int'(last_byte), 8'h42);

    // Reset in the middle of bit 4 of 0xC3, held until that frame ends
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) send_bit(logic'(i < 2));
    rx = 1'b0;
    wait_cycles(200);
    reset = 1'b1;
    wait_cycles(2);
    check("midreset_busy", int'(busy), 0);
    check("midreset_rx_data", int'(rx_data), 0);
    wait_cycles(CPB - 202);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b0;
    wait_cycles(50);
    $display("[TB] mid-frame reset: %0d strobes", valid_cnt - v0);
    check("midreset_no_valid", valid_cnt - v0, 0);
    check("midreset_no_ferr", ferr_cnt - f0, 0);
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1);
    wait_cycles(20);
    $display("[TB] frame 0x5A -> rx_data 0x%02h", last_byte);
    check("after_reset_valid", valid_cnt - v0, 1);
    check("after_reset_data", int'(rx_data), 8'h5A);

`ifdef UART_RX_PARITY_EN
    check("parity_clean_frames", perr_cnt, 0);
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame_bad_par(8'h01);
    wait_cycles(20);
    $display("[TB] bad-parity frame 0x01 -> rx_data 0x%02h", last_byte);
    check("parity_err_with_valid", perr_cnt - p0, 1);
    check("parity_valid", valid_cnt - v0, 1);
    check("parity_rx_data", int'(rx_data), 8'h01);
`endif

    check("strobes_never_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
